tile_fill: RTL and testbench
============================

TILE_FILL -- requirements
Module: tile_fill

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning tile columns (640/20).
REQ-002 SHALL have parameter ROWS, default 24, meaning tile rows (480/20); depth COLS*ROWS = 768 bytes.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  fill command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x0  input  5  left tile column.
REQ-008 cmd_y0  input  5  top tile row.
REQ-009 cmd_w  input  6  rectangle width in tiles, 0..32.
REQ-010 cmd_h  input  5  rectangle height in tiles, 0..24.
REQ-011 cmd_color  input  8  RRRGGGBB fill colour.
REQ-012 busy  output  1  CLEAR or FILL in progress.
REQ-013 done  output  1  one-cycle pulse at command completion.
REQ-014 rd_addr  input  16  display read address, y*COLS+x, driven by the display-side pixel fetch.
REQ-015 rd_color  output  8  colour stored at rd_addr.

Function
REQ-016 SHALL implement FSM states CLEAR, IDLE, FILL, DONE.
REQ-017 Reset exit SHALL start in CLEAR: write 0x00 to addresses 0..767, one per cycle, ascending; after address 767 go to IDLE; no done pulse for CLEAR.
REQ-018 cmd_ready SHALL be 1 only in IDLE; command accepted on cycle where cmd_valid && cmd_ready; cmd_valid in other states ignored, not queued.
REQ-019 On accept SHALL latch all cmd_* fields and clip: w_eff = min(cmd_w, COLS-cmd_x0); h_eff = min(cmd_h, ROWS-cmd_y0), h_eff = 0 if cmd_y0 >= ROWS.
REQ-020 If w_eff == 0 or h_eff == 0, SHALL go IDLE -> DONE directly, no writes.
REQ-021 Otherwise SHALL enter FILL, writing one tile per cycle, row-major: x from x0 to x0+w_eff-1, then y increments and x wraps to x0, until (x0+w_eff-1, y0+h_eff-1).
REQ-022 Write address SHALL be y*COLS+x, computed at >=10 bits without truncation.
REQ-023 Write count SHALL equal w_eff*h_eff exactly; FILL lasts w_eff*h_eff cycles.
REQ-024 After last write SHALL enter DONE for one cycle with done=1, then IDLE; earliest next accept is the cycle after DONE.
REQ-025 busy SHALL be 1 in CLEAR and FILL, 0 in IDLE and DONE.
REQ-026 rd_color SHALL be combinational from rd_addr: memory[rd_addr] for rd_addr < 768, else 0x00.
REQ-027 Same-cycle read and write to one address SHALL return the old value; new value visible from next cycle.
REQ-028 Memory outside the clipped rectangle SHALL be unchanged by a fill.

Reset
REQ-029 rst_n low SHALL immediately force: state CLEAR-pending, cmd_ready=0, busy=1, done=0, counters 0.
REQ-030 Reset mid-FILL SHALL abandon the command with no done pulse; the following CLEAR zeroes all 768 tiles.
REQ-031 Memory contents SHALL not be asynchronously reset; zeroing happens only through CLEAR.

Verification
REQ-032 Release reset, wait -> busy=1 for 768 cycles then cmd_ready=1; rd_addr 0..767 all read 0x00.
REQ-033 Fill x0=2,y0=3,w=4,h=2,color=0xE0 -> 8 FILL cycles, done one cycle; addr 98..101 and 130..133 read 0xE0; addr 97, 102, 162 read 0x00.
REQ-034 Fill x0=30,y0=22,w=5,h=5,color=0x03 -> clipped to 2x2, 4 write cycles; addr 734,735,766,767 read 0x03; done pulses once.
REQ-035 Fill w=0, or y0=24 -> no writes, done asserted cycle after accept, memory unchanged.
REQ-036 Hold cmd_valid=1 during FILL with changed fields -> ignored; only the accepted command writes; second accept after return to IDLE.
REQ-037 Assert rst_n low mid-FILL of full-screen 0xFF -> no done; after CLEAR all 768 addresses read 0x00; rd_addr=800 reads 0x00.

Source files
------------

// File: rtl/tile_fill.sv
// rtl/tile_fill.sv - tile colour framebuffer with power-on clear and clipped rectangle fill
// Combinational read port for the display; one write per cycle from the CLEAR/FILL sequencer.
module tile_fill #(
  parameter int COLS = 32,
  parameter int ROWS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_x0,
  input  logic [4:0]  cmd_y0,
  input  logic [5:0]  cmd_w,
  input  logic [4:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        busy,
  output logic        done,
  input  logic [15:0] rd_addr,
  output logic [7:0]  rd_color
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [6:0]    r_x;
  logic [6:0]    r_y;
  logic [6:0]    r_x0;
  logic [6:0]    r_xend;
  logic [6:0]    r_yend;
  logic [7:0]    r_color;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic [7:0]    r_mem [0:DEPTH-1];

  logic [6:0]    w_wroom;
  logic [6:0]    w_hroom;
  logic [6:0]    w_weff;
  logic [6:0]    w_heff;
  logic          w_accept;
  logic [AW-1:0] w_fill_addr;
  logic          w_we;
  logic [AW-1:0] w_wa;
  logic [7:0]    w_wd;
  logic          w_rd_in;

  // Clip against the right/bottom edges; an origin past the edge yields zero room.
  assign w_wroom  = ({2'b00, cmd_x0} >= 7'(COLS)) ? 7'd0 : 7'(COLS) - {2'b00, cmd_x0};
  assign w_hroom  = ({2'b00, cmd_y0} >= 7'(ROWS)) ? 7'd0 : 7'(ROWS) - {2'b00, cmd_y0};
  assign w_weff   = ({1'b0, cmd_w} < w_wroom) ? {1'b0, cmd_w} : w_wroom;
  assign w_heff   = ({2'b00, cmd_h} < w_hroom) ? {2'b00, cmd_h} : w_hroom;
  assign w_accept = cmd_valid && r_ready;

  assign w_fill_addr = AW'(32'(r_y) * COLS + 32'(r_x));

  assign w_we = rst_n && ((r_state == ST_CLEAR) || (r_state == ST_FILL));
  assign w_wa = (r_state == ST_CLEAR) ? r_cnt : w_fill_addr;
  assign w_wd = (r_state == ST_CLEAR) ? 8'h00 : r_color;

  // Memory has no reset; zeroing is done by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  assign w_rd_in  = (rd_addr < 16'(DEPTH));
  assign rd_color = w_rd_in ? r_mem[rd_addr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_xend  <= '0;
      r_yend  <= '0;
      r_color <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_color <= cmd_color;
            r_x     <= {2'b00, cmd_x0};
            r_y     <= {2'b00, cmd_y0};
            r_x0    <= {2'b00, cmd_x0};
            r_xend  <= {2'b00, cmd_x0} + w_weff - 7'd1;
            r_yend  <= {2'b00, cmd_y0} + w_heff - 7'd1;
            if ((w_weff == 7'd0) || (w_heff == 7'd0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FILL;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (r_x == r_xend) begin
            r_x <= r_x0;
            if (r_y == r_yend) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_y <= r_y + 7'd1;
            end
          end else begin
            r_x <= r_x + 7'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_tile_fill.sv
// tb/tb_tile_fill.sv - self-checking bench for tile_fill
// Reference model is a plain byte array updated by bounds-checked nested loops.
module tb_tile_fill;

  localparam int COLS  = 32;
  localparam int ROWS  = 24;
  localparam int DEPTH = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_x0;
  logic [4:0]  cmd_y0;
  logic [5:0]  cmd_w;
  logic [4:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        busy;
  logic        done;
  logic [15:0] rd_addr;
  logic [7:0]  rd_color;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [DEPTH];

  tile_fill dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_color  (rd_color)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_fill(input int x0, input int y0, input int w, input int h,
                                    input logic [7:0] c);
    int n = 0;
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < COLS && y < ROWS) begin
          model[y * COLS + x] = c;
          n++;
        end
    return n;
  endfunction

  task automatic sweep(output int bad, output int first_bad);
    bad = 0;
    first_bad = -1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 16'(a);
      #1;
      if (rd_color !== model[a]) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [4:0] x0, input logic [4:0] y0, input logic [5:0] w,
                          input logic [4:0] h, input logic [7:0] c, input bit hold,
                          output int busy_n, output int lat, output int done_n,
                          output bit tmo, output logic [7:0] rd0, output logic [7:0] rd1);
    int k;
    busy_n = 0; lat = 0; done_n = 0; tmo = 1'b0; rd0 = 8'h00; rd1 = 8'h00;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (cmd_ready !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    cmd_valid = 1'b1; cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_x0    = x0 ^ 5'd1;
      cmd_color = ~c;
    end else begin
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    rd0 = rd_color;
    rd1 = rd_color;
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      if (k == 0) rd1 = rd_color;
      k++;
    end
    if (done !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    lat = k + 1;
    while (done === 1'b1 && k < 3000) begin
      done_n++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int cnt, bad, fb;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_outputs: ready/busy/done=%b required 010", {cmd_ready, busy, done});
    end
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 768) begin
      n_fail++;
      $display("FAIL clear_cycles: busy for %0d cycles required 768", cnt);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_clear: cmd_ready=%b required 1", cmd_ready);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clear_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
  endtask

  task automatic test_fill_basic();
    int busy_n, lat, done_n, bad, fb, n;
    bit tmo;
    logic [7:0] rd0, rd1, exp;
    int a_list[11] = '{98, 99, 100, 101, 130, 131, 132, 133, 97, 102, 162};
    rd_addr = 16'd98;
    n = model_fill(2, 3, 4, 2, 8'hE0);
    send_cmd(5'd2, 5'd3, 6'd4, 5'd2, 8'hE0, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== n || lat !== n + 1 || done_n !== 1) begin
      n_fail++;
      $display("FAIL basic_timing: tmo=%0d busy=%0d lat=%0d done=%0d required 0 %0d %0d 1",
               tmo, busy_n, lat, done_n, n, n + 1);
    end
    n_checks++;
    if (rd0 !== 8'h00 || rd1 !== 8'hE0) begin
      n_fail++;
      $display("FAIL read_during_write: got %h then %h required 00 then e0", rd0, rd1);
    end
    for (int i = 0; i < 11; i++) begin
      exp = (i < 8) ? 8'hE0 : 8'h00;
      rd_addr = 16'(a_list[i]);
      #1;
      n_checks++;
      if (rd_color !== exp) begin
        n_fail++;
        $display("FAIL basic_addr_%0d: got %h required %h", a_list[i], rd_color, exp);
      end
    end
    rd_addr = 16'd1122;
    #1;
    n_checks++;
    if (rd_color !== 8'h00) begin
      n_fail++;
      $display("FAIL oob_alias_1122: got %h required 00", rd_color);
    end
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL basic_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
  endtask

  task automatic test_clip();
    int busy_n, lat, done_n, bad, fb, n;
    bit tmo;
    logic [7:0] rd0, rd1;
    int a_list[4] = '{734, 735, 766, 767};
    n = model_fill(30, 22, 5, 5, 8'h03);
    send_cmd(5'd30, 5'd22, 6'd5, 5'd5, 8'h03, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== 4 || n !== 4 || lat !== 5 || done_n !== 1) begin
      n_fail++;
      $display("FAIL clip_timing: tmo=%0d busy=%0d lat=%0d done=%0d required 0 4 5 1",
               tmo, busy_n, lat, done_n);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 16'(a_list[i]);
      #1;
      n_checks++;
      if (rd_color !== 8'h03) begin
        n_fail++;
        $display("FAIL clip_addr_%0d: got %h required 03", a_list[i], rd_color);
      end
    end
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clip_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
  endtask

  task automatic test_empty();
    int busy_n, lat, done_n, bad, fb;
    bit tmo;
    logic [7:0] rd0, rd1;
    send_cmd(5'd5, 5'd5, 6'd0, 5'd3, 8'h55, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== 0 || lat !== 1 || done_n !== 1) begin
      n_fail++;
      $display("FAIL empty_w0: tmo=%0d busy=%0d lat=%0d done=%0d required 0 0 1 1",
               tmo, busy_n, lat, done_n);
    end
    send_cmd(5'd4, 5'd24, 6'd4, 5'd2, 8'hAA, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== 0 || lat !== 1 || done_n !== 1) begin
      n_fail++;
      $display("FAIL empty_y24: tmo=%0d busy=%0d lat=%0d done=%0d required 0 0 1 1",
               tmo, busy_n, lat, done_n);
    end
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL empty_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n, lat, done_n, bad, fb, na, nb;
    bit tmo;
    logic [7:0] rd0, rd1;
    na = model_fill(1, 1, 6, 3, 8'h1C);
    send_cmd(5'd1, 5'd1, 6'd6, 5'd3, 8'h1C, 1'b1, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== na || done_n !== 1) begin
      n_fail++;
      $display("FAIL hold_first: tmo=%0d busy=%0d done=%0d required 0 %0d 1",
               tmo, busy_n, done_n, na);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_idle_after_done: cmd_ready=%b required 1", cmd_ready);
    end
    nb = model_fill(0, 1, 6, 3, 8'hE3);
    send_cmd(5'd0, 5'd1, 6'd6, 5'd3, 8'hE3, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
    n_checks++;
    if (tmo || busy_n !== nb || lat !== nb + 1 || done_n !== 1) begin
      n_fail++;
      $display("FAIL hold_second: tmo=%0d busy=%0d lat=%0d done=%0d required 0 %0d %0d 1",
               tmo, busy_n, lat, done_n, nb, nb + 1);
    end
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
  endtask

  task automatic test_random();
    int busy_n, lat, done_n, bad, fb, n;
    bit tmo;
    logic [7:0] rd0, rd1, c;
    logic [4:0] x0, y0, h;
    logic [5:0] w;
    for (int i = 0; i < 20; i++) begin
      x0 = 5'($urandom_range(31, 0));
      y0 = 5'($urandom_range(31, 0));
      w  = 6'($urandom_range(32, 0));
      h  = 5'($urandom_range(24, 0));
      c  = 8'($urandom);
      n  = model_fill(int'(x0), int'(y0), int'(w), int'(h), c);
      send_cmd(x0, y0, w, h, c, 1'b0, busy_n, lat, done_n, tmo, rd0, rd1);
      n_checks++;
      if (tmo || busy_n !== n || lat !== n + 1 || done_n !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_timing (x0=%0d y0=%0d w=%0d h=%0d): tmo=%0d busy=%0d lat=%0d done=%0d required 0 %0d %0d 1",
                 i, x0, y0, w, h, tmo, busy_n, lat, done_n, n, n + 1);
      end
      sweep(bad, fb);
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_contents: %0d bad addresses (first %0d) required 0", i, bad, fb);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int k, cnt, bad, fb;
    bit saw_done;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b1; cmd_x0 = 5'd0; cmd_y0 = 5'd0; cmd_w = 6'd32; cmd_h = 5'd24;
    cmd_color = 8'hFF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    saw_done = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midfill_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL async_reset: ready/busy/done=%b required 010", {cmd_ready, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      if (done === 1'b1) saw_done = 1'b1;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (saw_done || cnt !== 768) begin
      n_fail++;
      $display("FAIL midfill_reclear: done_seen=%0d clear_cycles=%0d required 0 768", saw_done, cnt);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
    sweep(bad, fb);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midfill_contents: %0d bad addresses (first %0d) required 0", bad, fb);
    end
    rd_addr = 16'd800;
    #1;
    n_checks++;
    if (rd_color !== 8'h00) begin
      n_fail++;
      $display("FAIL oob_800: got %h required 00", rd_color);
    end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_clip();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
